corking_station: RTL
====================

CORKING_STATION -- requirements
Module: corking_station

Interface
REQ-001 SHALL provide parameter LOW_MARK, default 8'd5, line-count threshold at or below which a refill is requested.
REQ-002 SHALL provide parameter CORK_CYCLES, default 4, number of cycles the press spends in CORK (legal range 1..15).
REQ-003 SHALL have the port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have the port bottle_present, input, 1 bit: a bottle is under the press sensor.
REQ-006 SHALL have the port batch_valid, input, 1 bit: the stock dispenser is delivering a batch this cycle.
REQ-007 SHALL have the port batch_qty, input, 8 bits: number of corks in the delivered batch.
REQ-008 SHALL have the port stock_alert, input, 1 bit: the upstream stock is low or empty.
REQ-009 SHALL have the port req_refill, output, 1 bit: line buffer at or below LOW_MARK.
REQ-010 SHALL have the port batch_ack, output, 1 bit: one-cycle registered acknowledge of an accepted batch.
REQ-011 SHALL have the port done, output, 1 bit: one-cycle pulse per corked bottle.
REQ-012 SHALL have the port line_count, output, 8 bits: corks currently held at the station.
REQ-013 SHALL have the port conveyor_run, output, 1 bit: conveyor motor enable.
REQ-014 SHALL have the port fault_no_cork, output, 1 bit: a bottle is waiting with no cork available.
REQ-015 SHALL have the port overflow, output, 1 bit: sticky flag, line_count saturated.
REQ-016 SHALL have the port bottles_corked, output, 16 bits: total number of bottles corked.
REQ-017 SHALL have the port state, output, 3 bits: FSM state code.

Function
REQ-018 FSM SHALL have states IDLE=0, POSITION=1, CORK=2, RELEASE=3, STARVED=4; unused codes return to IDLE on the next clock.
REQ-019 IDLE: conveyor_run=1; if bottle_present and line_count>0, go to POSITION; if bottle_present and line_count==0, go to STARVED.
REQ-020 POSITION: conveyor_run=0; one cycle; load the press timer with CORK_CYCLES-1; go to CORK.
REQ-021 CORK: conveyor_run=0; the timer decrements each cycle; when timer==0, go to RELEASE, line_count decrements by 1, done=1 for exactly that cycle, and bottles_corked increments.
REQ-022 bottles_corked SHALL wrap from 16'hFFFF to 0.
REQ-023 RELEASE: conveyor_run=1; go to IDLE on the first cycle bottle_present==0; no second cork is applied to the same bottle.
REQ-024 STARVED: conveyor_run=0 and fault_no_cork=1; go to POSITION on the first cycle line_count>0.
REQ-025 Batch acceptance: when batch_valid=1 and batch_qty!=0 in a cycle, line_count += batch_qty on that edge and batch_ack=1 on the following cycle.
REQ-026 A batch with batch_qty==0 SHALL NOT be acknowledged.
REQ-027 Batch SHALL be accepted in every state.
REQ-028 Simultaneous batch and CORK-completion decrement SHALL apply both in the same cycle: line_count_next = line_count + batch_qty - 1.
REQ-029 Arithmetic SHALL be 9-bit internally; a result >255 SHALL clamp line_count to 255 and set overflow.
REQ-030 overflow SHALL be cleared only by reset.
REQ-031 line_count SHALL never go below 0; the decrement only occurs from CORK, which requires line_count>0 at POSITION entry.
REQ-032 req_refill = (line_count <= LOW_MARK), combinational from the register.
REQ-033 stock_alert SHALL be status only and SHALL NOT alter FSM transitions.
REQ-034 done, batch_ack and fault_no_cork SHALL be registered outputs.

Reset
REQ-035 On reset assertion, all registers SHALL clear immediately and asynchronously: state=IDLE, line_count=0, bottles_corked=0, done=0, batch_ack=0, overflow=0, fault_no_cork=0, timer=0.
REQ-036 While in reset, conveyor_run=1 and req_refill=1.
REQ-037 Reset in mid-CORK SHALL abort without a done pulse and without decrementing line_count.

Verification
REQ-038 Scenario: reset, then batch_valid=1 with batch_qty=15 for one cycle -> line_count=15, batch_ack pulse one cycle later, req_refill falls to 0.
REQ-039 Scenario: line_count=15, bottle_present held high -> POSITION then 4 CORK cycles, done pulse, line_count=14, conveyor_run=0 throughout POSITION and CORK.
REQ-040 Scenario: line_count=0, bottle arrives -> STARVED with fault_no_cork=1; batch of 15 delivered -> POSITION next cycle, bottle corked, line_count=14.
REQ-041 Scenario: line_count=1 with a batch of 15 in the same cycle as CORK completion -> line_count=15 and done=1.
REQ-042 Scenario: line_count=250 plus a batch of 15 -> line_count=255 and overflow=1; overflow stays 1 until reset.
REQ-043 Scenario: reset pulsed at CORK timer=2 -> state=IDLE, no done pulse, line_count unchanged at 0 after reset, bottles_corked=0.

Source files
------------

// File: rtl/corking_station.sv
// Corking station controller: moves bottles under the press, applies one cork per
// bottle and tracks the cork buffer that is refilled from the stock dispenser.
module corking_station #(
   parameter logic [7:0] LOW_MARK    = 8'd5,
   parameter int         CORK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bottle_present,
   input  logic        batch_valid,
   input  logic [7:0]  batch_qty,
   input  logic        stock_alert,
   output logic        req_refill,
   output logic        batch_ack,
   output logic        done,
   output logic [7:0]  line_count,
   output logic        conveyor_run,
   output logic        fault_no_cork,
   output logic        overflow,
   output logic [15:0] bottles_corked,
   output logic [2:0]  state
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] POSITION = 3'd1;
   localparam logic [2:0] CORK     = 3'd2;
   localparam logic [2:0] RELEASE  = 3'd3;
   localparam logic [2:0] STARVED  = 3'd4;

   localparam logic [3:0] TIMER_LOAD = 4'(CORK_CYCLES - 1);

   logic [2:0] state_next;
   logic [3:0] timer;
   logic       cork_fire;
   logic       accept;
   logic [8:0] count_sum;

   // stock_alert is reported upstream only; it deliberately has no effect here.
   logic unused_stock_alert;
   assign unused_stock_alert = stock_alert;

   function automatic logic [8:0] count_update(input logic [7:0] cur,
                                               input logic [7:0] add,
                                               input logic       sub);
      return {1'b0, cur} + {1'b0, add} - {8'd0, sub};
   endfunction

   function automatic logic [7:0] clamp_count(input logic [8:0] v);
      return v[8] ? 8'hFF : v[7:0];
   endfunction

   assign cork_fire = (state == CORK) && (timer == 4'd0);
   assign accept    = batch_valid && (batch_qty != 8'd0);
   assign count_sum = count_update(line_count, accept ? batch_qty : 8'd0, cork_fire);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE: begin
            if (bottle_present && line_count != 8'd0)      state_next = POSITION;
            else if (bottle_present)                       state_next = STARVED;
            else                                           state_next = IDLE;
         end
         POSITION: state_next = CORK;
         CORK:     state_next = (timer == 4'd0) ? RELEASE : CORK;
         RELEASE:  state_next = bottle_present ? RELEASE : IDLE;
         STARVED:  state_next = (line_count != 8'd0) ? POSITION : STARVED;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      conveyor_run = 1'b1;
      case (state)
         POSITION, CORK, STARVED: conveyor_run = 1'b0;
         default:                 conveyor_run = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer <= 4'd0;
      end else if (state == POSITION) begin
         timer <= TIMER_LOAD;
      end else if (state == CORK && timer != 4'd0) begin
         timer <= timer - 4'd1;
      end
   end

   // A batch and a cork completion in the same cycle are folded into one update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_count <= 8'd0;
         overflow   <= 1'b0;
      end else begin
         line_count <= clamp_count(count_sum);
         if (count_sum[8]) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done           <= 1'b0;
         batch_ack      <= 1'b0;
         fault_no_cork  <= 1'b0;
         bottles_corked <= 16'd0;
      end else begin
         done          <= cork_fire;
         batch_ack     <= accept;
         fault_no_cork <= (state_next == STARVED);
         if (cork_fire) bottles_corked <= bottles_corked + 16'd1;
      end
   end

   assign req_refill = (line_count <= LOW_MARK);

endmodule
